mem_access_unit: RTL and testbench

//   Memory-stage load/store unit. Consumes the decode-stage memory controls (mem_write, wb_load,
//   mem_store_type, mem_load_type) carried down the pipeline, drives a variable-latency data-memory
//   req/ready port, and stalls the pipeline until the access completes. Produces byte enables and

---
 rtl/mem_access_unit.sv | 207 ++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: issues one data-memory request per load/store,
// stalls the pipeline until completion and formats load data for writeback.
module mem_access_unit #(
    parameter int ADDR_WIDTH  = 32,
    parameter int REQ_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid,
    input  logic                  mem_write,
    input  logic                  wb_load,
    input  logic [1:0]            mem_store_type,
    input  logic [2:0]            mem_load_type,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           store_data,
    output logic                  stall,
    output logic [31:0]           load_data,
    output logic                  load_valid,
    output logic                  misaligned,
    output logic                  bus_err,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [ADDR_WIDTH-1:0] dmem_addr,
    output logic [3:0]            dmem_be,
    output logic [31:0]           dmem_wdata,
    input  logic                  dmem_ready,
    input  logic [31:0]           dmem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    localparam int CW = (REQ_TIMEOUT < 2) ? 1 : $clog2(REQ_TIMEOUT + 1);

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   dmem_addr_q, dmem_addr_d;
    logic                    dmem_we_q, dmem_we_d;
    logic [3:0]              dmem_be_q, dmem_be_d;
    logic [31:0]             dmem_wdata_q, dmem_wdata_d;
    logic [31:0]             load_data_q, load_data_d;
    logic                    load_valid_q, load_valid_d;
    logic                    misaligned_q, misaligned_d;
    logic                    bus_err_q, bus_err_d;
    logic [2:0]              ld_type_q, ld_type_d;
    logic [1:0]              byte_off_q, byte_off_d;

    logic is_store, access, mis_addr, timeout_hit;

    function automatic logic [31:0] format_load(input logic [2:0]  lt,
                                                input logic [1:0]  off,
                                                input logic [31:0] rd);
        logic [31:0] sh;
        logic [15:0] half;
        sh   = rd >> {off, 3'b000};
        half = off[1] ? rd[31:16] : rd[15:0];
        case (lt)
            3'b000:  return {{24{sh[7]}}, sh[7:0]};
            3'b011:  return {24'h0, sh[7:0]};
            3'b001:  return {{16{half[15]}}, half};
            3'b100:  return {16'h0, half};
            default: return rd;
        endcase
    endfunction

    // A store with type 11 writes nothing, so only then can a co-asserted load win.
    assign is_store    = mem_write && (mem_store_type != 2'b11);
    assign access      = valid && (is_store || wb_load);
    assign timeout_hit = (REQ_TIMEOUT != 0) && (cnt_q == CW'(REQ_TIMEOUT - 1));

    always_comb begin
        mis_addr = 1'b0;
        if (is_store) begin
            case (mem_store_type)
                2'b01:   mis_addr = addr[0];
                2'b10:   mis_addr = (addr[1:0] != 2'b00);
                default: mis_addr = 1'b0;
            endcase
        end else begin
            case (mem_load_type)
                3'b000, 3'b011: mis_addr = 1'b0;
                3'b001, 3'b100: mis_addr = addr[0];
                default:        mis_addr = (addr[1:0] != 2'b00);
            endcase
        end
    end

    // NOTE: async reset clears all state flops; sequential blocks use only non-blocking assignments.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            dmem_addr_q  <= '0;
            dmem_we_q    <= 1'b0;
            dmem_be_q    <= 4'b0;
            dmem_wdata_q <= 32'h0;
            load_data_q  <= 32'h0;
            load_valid_q <= 1'b0;
            misaligned_q <= 1'b0;
            bus_err_q    <= 1'b0;
            ld_type_q    <= 3'b0;
            byte_off_q   <= 2'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_we_q    <= dmem_we_d;
            dmem_be_q    <= dmem_be_d;
            dmem_wdata_q <= dmem_wdata_d;
            load_data_q  <= load_data_d;
            load_valid_q <= load_valid_d;
            misaligned_q <= misaligned_d;
            bus_err_q    <= bus_err_d;
            ld_type_q    <= ld_type_d;
            byte_off_q   <= byte_off_d;
        end
    end

    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (access) state_d = mis_addr ? DONE : REQ;
            end
            REQ: begin
                cnt_d = cnt_q + CW'(1);
                if (dmem_ready || timeout_hit) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stall        = 1'b0;
        dmem_req     = 1'b0;
        dmem_addr_d  = dmem_addr_q;
        dmem_we_d    = dmem_we_q;
        dmem_be_d    = dmem_be_q;
        dmem_wdata_d = dmem_wdata_q;
        ld_type_d    = ld_type_q;
        byte_off_d   = byte_off_q;
        load_data_d  = load_data_q;
        load_valid_d = 1'b0;
        misaligned_d = 1'b0;
        bus_err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                stall = access;
                if (access && mis_addr) begin
                    misaligned_d = 1'b1;
                    load_data_d  = 32'h0;
                end else if (access) begin
                    dmem_addr_d = {addr[ADDR_WIDTH-1:2], 2'b00};
                    dmem_we_d   = is_store;
                    ld_type_d   = mem_load_type;
                    byte_off_d  = addr[1:0];
                    if (is_store) begin
                        case (mem_store_type)
                            2'b00: begin
                                dmem_be_d    = 4'b0001 << addr[1:0];
                                dmem_wdata_d = {4{store_data[7:0]}};
                            end
                            2'b01: begin
                                dmem_be_d    = 4'b0011 << {addr[1], 1'b0};
                                dmem_wdata_d = {2{store_data[15:0]}};
                            end
                            default: begin
                                dmem_be_d    = 4'b1111;
                                dmem_wdata_d = store_data;
                            end
                        endcase
                    end else begin
                        dmem_be_d    = 4'b1111;
                        dmem_wdata_d = 32'h0;
                    end
                end
            end
            REQ: begin
                stall    = 1'b1;
                dmem_req = 1'b1;
                if (dmem_ready) begin
                    if (!dmem_we_q) begin
                        load_valid_d = 1'b1;
                        load_data_d  = format_load(ld_type_q, byte_off_q, dmem_rdata);
                    end
                end else if (timeout_hit) begin
                    bus_err_d   = 1'b1;
                    load_data_d = 32'h0;
                end
            end
            default: ;
        endcase
    end

    assign load_data  = load_data_q;
    assign load_valid = load_valid_q;
    assign misaligned = misaligned_q;
    assign bus_err    = bus_err_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_be    = dmem_be_q;
    assign dmem_wdata = dmem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with REQ_TIMEOUT=4; inputs change on the
// falling edge and outputs are sampled 1 time unit later.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0, mem_write = 1'b0, wb_load = 1'b0;
    logic [1:0]  mem_store_type = 2'b11;
    logic [2:0]  mem_load_type = 3'b000;
    logic [31:0] addr = 32'h0, store_data = 32'h0;
    logic        stall, load_valid, misaligned, bus_err;
    logic [31:0] load_data;
    logic        dmem_req, dmem_we, dmem_ready = 1'b0;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = 32'h0;
    logic [3:0]  dmem_be;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    mem_access_unit #(.ADDR_WIDTH(32), .REQ_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .valid(valid), .mem_write(mem_write), .wb_load(wb_load),
        .mem_store_type(mem_store_type), .mem_load_type(mem_load_type), .addr(addr),
        .store_data(store_data), .stall(stall), .load_data(load_data),
        .load_valid(load_valid), .misaligned(misaligned), .bus_err(bus_err),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic store_txn(input logic [1:0] st, input logic [31:0] a, input logic [31:0] sd,
                             output logic [31:0] o_addr, output logic [3:0] o_be,
                             output logic [31:0] o_wd, output logic o_we,
                             output int sc, output int pulses);
        @(negedge clk);
        valid = 1'b1; mem_write = 1'b1; wb_load = 1'b0;
        mem_store_type = st; addr = a; store_data = sd;
        #1 sc = int'(stall);
        @(negedge clk);
        #1;
        o_addr = dmem_addr; o_be = dmem_be; o_wd = dmem_wdata; o_we = dmem_we;
        sc += int'(stall);
        dmem_ready = 1'b1;
        @(negedge clk);
        dmem_ready = 1'b0;
        #1 sc += int'(stall);
        pulses = int'(load_valid) + int'(misaligned) + int'(bus_err);
        valid = 1'b0; mem_write = 1'b0;
    endtask

    task automatic load_txn(input logic [2:0] lt, input logic [31:0] a, input logic [31:0] rd,
                            input int waits, output logic [31:0] ld, output logic lv,
                            output logic lv_after, output int sc, output int rq);
        @(negedge clk);
        valid = 1'b1; mem_write = 1'b0; wb_load = 1'b1; mem_load_type = lt; addr = a;
        #1 sc = int'(stall);
        rq = int'(dmem_req);
        for (int i = 0; i < waits; i++) begin
            @(negedge clk);
            #1 sc += int'(stall);
            rq += int'(dmem_req);
        end
        @(negedge clk);
        dmem_ready = 1'b1; dmem_rdata = rd;
        #1 sc += int'(stall);
        rq += int'(dmem_req);
        @(negedge clk);
        dmem_ready = 1'b0; dmem_rdata = $urandom();
        #1 sc += int'(stall);
        ld = load_data; lv = load_valid;
        valid = 1'b0; wb_load = 1'b0;
        @(negedge clk);
        #1 lv_after = load_valid;
    endtask

    initial begin
        logic [31:0] o_addr, o_wd, ld;
        logic [3:0]  o_be;
        logic        o_we, lv, lv_after;
        int          sc, pulses, rq, err_at;

        // Reset state
        #2;
        check("rst_req", 32'(dmem_req), 32'h0);
        check("rst_stall", 32'(stall), 32'h0);
        check("rst_load_data", load_data, 32'h0);
        check("rst_be", 32'(dmem_be), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // SB at byte 3
        store_txn(2'b00, 32'h0000_1003, 32'h0000_00AB, o_addr, o_be, o_wd, o_we, sc, pulses);
        check("sb_addr", o_addr, 32'h0000_1000);
        check("sb_be", 32'(o_be), 32'h8);
        check("sb_wdata", o_wd, 32'hABAB_ABAB);
        check("sb_we", 32'(o_we), 32'h1);
        check("sb_stall", 32'(sc), 32'd2);
        check("sb_pulses", 32'(pulses), 32'd0);

        // SH upper half, SW
        store_txn(2'b01, 32'h0000_1002, 32'h1234_BEEF, o_addr, o_be, o_wd, o_we, sc, pulses);
        check("sh_be", 32'(o_be), 32'hC);
        check("sh_wdata", o_wd, 32'hBEEF_BEEF);
        store_txn(2'b10, 32'h0000_1004, 32'h1234_5678, o_addr, o_be, o_wd, o_we, sc, pulses);
        check("sw_addr", o_addr, 32'h0000_1004);
        check("sw_be", 32'(o_be), 32'hF);
        check("sw_wdata", o_wd, 32'h1234_5678);

        // LB with 3 wait cycles
        load_txn(3'b000, 32'h0000_2001, 32'h1234_8056, 3, ld, lv, lv_after, sc, rq);
        check("lb_data", ld, 32'hFFFF_FF80);
        check("lb_valid", 32'(lv), 32'h1);
        check("lb_valid_pulse", 32'(lv_after), 32'h0);
        check("lb_stall", 32'(sc), 32'd5);
        check("lb_req_cycles", 32'(rq), 32'd4);
        check("lb_hold", load_data, 32'hFFFF_FF80);

        // Halfword and byte variants
        load_txn(3'b100, 32'h0000_2002, 32'h8765_4321, 0, ld, lv, lv_after, sc, rq);
        check("lhu_data", ld, 32'h0000_8765);
        check("lhu_stall", 32'(sc), 32'd2);
        load_txn(3'b001, 32'h0000_2002, 32'h8765_4321, 0, ld, lv, lv_after, sc, rq);
        check("lh_data", ld, 32'hFFFF_8765);
        load_txn(3'b011, 32'h0000_2003, 32'h80AA_BBCC, 1, ld, lv, lv_after, sc, rq);
        check("lbu_data", ld, 32'h0000_0080);
        load_txn(3'b010, 32'h0000_2004, 32'hDEAD_BEEF, 0, ld, lv, lv_after, sc, rq);
        check("lw_data", ld, 32'hDEAD_BEEF);

        // Store type 11 without load: no access
        @(negedge clk);
        valid = 1'b1; mem_write = 1'b1; mem_store_type = 2'b11; wb_load = 1'b0;
        #1 check("nowrite_stall", 32'(stall), 32'h0);
        @(negedge clk);
        #1 check("nowrite_req", 32'(dmem_req), 32'h0);
        valid = 1'b0; mem_write = 1'b0;

        // Misaligned LW
        @(negedge clk);
        valid = 1'b1; wb_load = 1'b1; mem_load_type = 3'b010; addr = 32'h0000_3002;
        #1 check("mis_stall", 32'(stall), 32'h1);
        @(negedge clk);
        #1 check("mis_pulse", 32'(misaligned), 32'h1);
        check("mis_req", 32'(dmem_req), 32'h0);
        check("mis_load_data", load_data, 32'h0);
        check("mis_done_stall", 32'(stall), 32'h0);
        valid = 1'b0; wb_load = 1'b0;
        @(negedge clk);
        #1 check("mis_pulse_end", 32'(misaligned), 32'h0);

        // Timeout: first restore a nonzero load_data, then never answer
        load_txn(3'b010, 32'h0000_2008, 32'hCAFE_F00D, 0, ld, lv, lv_after, sc, rq);
        @(negedge clk);
        valid = 1'b1; wb_load = 1'b1; mem_load_type = 3'b010; addr = 32'h0000_4000;
        rq = 0; err_at = 0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            #1 rq += int'(dmem_req);
            if (bus_err && err_at == 0) begin
                err_at = i;
                check("to_load_data", load_data, 32'h0);
                valid = 1'b0; wb_load = 1'b0;
            end
        end
        check("to_req_cycles", 32'(rq), 32'd4);
        check("to_bus_err_cycle", 32'(err_at), 32'd5);
        load_txn(3'b010, 32'h0000_4004, 32'h1122_3344, 0, ld, lv, lv_after, sc, rq);
        check("after_to_data", ld, 32'h1122_3344);
        check("after_to_valid", 32'(lv), 32'h1);

        // Reset mid-REQ, late ready ignored
        @(negedge clk);
        valid = 1'b1; wb_load = 1'b1; mem_load_type = 3'b010; addr = 32'h0000_5000;
        @(negedge clk);
        #1 check("mid_req_before", 32'(dmem_req), 32'h1);
        rst = 1'b1; valid = 1'b0; wb_load = 1'b0;
        #1 check("mid_req_dropped", 32'(dmem_req), 32'h0);
        check("mid_load_data", load_data, 32'h0);
        dmem_ready = 1'b1; dmem_rdata = 32'h5555_AAAA;
        @(negedge clk);
        rst = 1'b0;
        lv = 1'b0; rq = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            lv |= load_valid;
            rq += int'(dmem_req);
        end
        dmem_ready = 1'b0;
        check("mid_no_valid", 32'(lv), 32'h0);
        check("mid_no_req", 32'(rq), 32'd0);
        load_txn(3'b000, 32'h0000_6002, 32'h007F_0000, 0, ld, lv, lv_after, sc, rq);
        check("post_rst_lb", ld, 32'h0000_007F);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
